imuldiv_mul_iter_param: RTL and testbench

//  Parametrised iterative shift-add multiplier, successor of the fixed 32-bit iterative mul unit.

---
 rtl/imuldiv_mul_pkg.sv | 12 +
 rtl/imuldiv_mul_iter_param_dpath.sv | 65 ++++++
 rtl/imuldiv_mul_iter_param.sv | 84 ++++++++
 tb/tb_imuldiv_mul_iter_param.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_mul_pkg.sv
// rtl/imuldiv_mul_pkg.sv - shared FSM encoding for the iterative multiplier
// Purpose: state type and state constants used by the multiplier control path.
// Ports: none (package).
package imuldiv_mul_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/imuldiv_mul_iter_param_dpath.sv
// rtl/imuldiv_mul_iter_param_dpath.sv - operand/product registers and shift-add logic
// Purpose: holds the magnitude-converted operands, the running partial product
//   and the result sign; performs one shift-add step per enabled cycle.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   load              latch |op_a|, |op_b|, result sign; clear partial product
//   step              one shift-add iteration
//   op_a, op_b        W-bit request operands
//   op_signed         operands are two's complement
//   result            2W-bit signed-corrected product (valid once iterations finish)
//   b_rem_zero        multiplier bits above the current LSB are all zero
module imuldiv_mul_iter_param_dpath #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           op_signed,
  output logic [2*W-1:0] result,
  output logic           b_rem_zero
);

  logic [2*W-1:0] a_reg;
  logic [2*W-1:0] res_reg;
  logic [W-1:0]   b_reg;
  logic           sign_reg;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;

  // The most-negative value negates to itself, which read unsigned is exactly
  // its magnitude, so no special case is needed.
  always_comb begin
    mag_a = (op_signed && op_a[W-1]) ? -op_a : op_a;
    mag_b = (op_signed && op_b[W-1]) ? -op_b : op_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      sign_reg <= 1'b0;
    end else if (load) begin
      a_reg    <= {{W{1'b0}}, mag_a};
      b_reg    <= mag_b;
      res_reg  <= '0;
      sign_reg <= op_signed & (op_a[W-1] ^ op_b[W-1]);
    end else if (step) begin
      if (b_reg[0]) begin
        res_reg <= res_reg + a_reg;
      end
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
    end
  end

  // Looks at the bits that will remain after this cycle's shift, so the FSM
  // can leave CALC on the same edge that consumes the last set bit.
  assign b_rem_zero = (b_reg[W-1:1] == '0);
  assign result     = sign_reg ? -res_reg : res_reg;

endmodule

// File: rtl/imuldiv_mul_iter_param.sv
// rtl/imuldiv_mul_iter_param.sv - parametrised iterative shift-add multiplier
// Purpose: full 2W-bit signed/unsigned product, one operation in flight,
//   optional early exit once the remaining multiplier bits are zero.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   mulreq_msg_a/_b       W-bit operands (multiplicand / multiplier)
//   mulreq_msg_signed     1: two's-complement operands
//   mulreq_val/_rdy       request handshake
//   mulresp_msg_result    2W-bit product, meaningful while mulresp_val
//   mulresp_val/_rdy      response handshake
module imuldiv_mul_iter_param
  import imuldiv_mul_pkg::*;
#(
  parameter int W          = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   mulreq_msg_a,
  input  logic [W-1:0]   mulreq_msg_b,
  input  logic           mulreq_msg_signed,
  input  logic           mulreq_val,
  output logic           mulreq_rdy,
  output logic [2*W-1:0] mulresp_msg_result,
  output logic           mulresp_val,
  input  logic           mulresp_rdy
);

  localparam int               CW         = $clog2(W);
  localparam logic [CW-1:0]    COUNT_LAST = CW'(W - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          load;
  logic          step;
  logic          b_rem_zero;
  logic          calc_done;

  assign mulreq_rdy  = (state == IDLE);
  assign mulresp_val = (state == DONE);
  assign load        = mulreq_val && mulreq_rdy;
  assign step        = (state == CALC);

  // The count exit is what bounds the counter; it never wraps.
  assign calc_done = (count == COUNT_LAST) || ((EARLY_TERM != 0) && b_rem_zero);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CALC;
      CALC:    if (calc_done) state_next = DONE;
      DONE:    if (mulresp_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        count <= '0;
      end else if (step) begin
        count <= count + CW'(1);
      end
    end
  end

  imuldiv_mul_iter_param_dpath #(.W(W)) u_dpath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .op_a       (mulreq_msg_a),
    .op_b       (mulreq_msg_b),
    .op_signed  (mulreq_msg_signed),
    .result     (mulresp_msg_result),
    .b_rem_zero (b_rem_zero)
  );

endmodule

// File: tb/tb_imuldiv_mul_iter_param.sv
// tb/tb_imuldiv_mul_iter_param.sv - self-checking bench for imuldiv_mul_iter_param
module tb_imuldiv_mul_iter_param;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0][31:0] a;
  logic [3:0][31:0] b;
  logic [3:0]       sgn;
  logic [3:0]       req_val;
  logic [3:0]       req_rdy;
  logic [3:0]       resp_val;
  logic [3:0]       resp_rdy;
  logic [3:0][63:0] res;
  int               checks   = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  // Instance g: W = 32 for g<2 else 8; EARLY_TERM = g%2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int WG  = (g < 2) ? 32 : 8;
    localparam int ETG = g % 2;
    logic [2*WG-1:0] res_w;
    imuldiv_mul_iter_param #(.W(WG), .EARLY_TERM(ETG)) u_dut (
      .clk                (clk),
      .reset              (reset),
      .mulreq_msg_a       (a[g][WG-1:0]),
      .mulreq_msg_b       (b[g][WG-1:0]),
      .mulreq_msg_signed  (sgn[g]),
      .mulreq_val         (req_val[g]),
      .mulreq_rdy         (req_rdy[g]),
      .mulresp_msg_result (res_w),
      .mulresp_val        (resp_val[g]),
      .mulresp_rdy        (resp_rdy[g])
    );
    assign res[g] = 64'(res_w);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] op_mask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference: extend each operand to 64 bits by its own signedness, multiply,
  // keep the low 2W bits.
  function automatic logic [63:0] model_product(input int w, input logic [31:0] x,
                                                input logic [31:0] y, input logic s);
    logic [63:0] ex, ey, pmask;
    ex = 64'(x & op_mask(w));
    ey = 64'(y & op_mask(w));
    if (s && ex[w-1]) ex = ex | (~64'd0 << w);
    if (s && ey[w-1]) ey = ey | (~64'd0 << w);
    pmask = (w == 32) ? ~64'd0 : ((64'd1 << (2 * w)) - 64'd1);
    return (ex * ey) & pmask;
  endfunction

  // Cycles from the accept edge to the first cycle with mulresp_val high.
  function automatic int model_latency(input int w, input int et, input logic [31:0] y,
                                       input logic s);
    logic [31:0] yv, mag;
    int n;
    if (et == 0) return w + 1;
    yv  = y & op_mask(w);
    mag = (s && yv[w-1]) ? ((~yv + 32'd1) & op_mask(w)) : yv;
    n = 1;
    for (int i = 0; i < w; i++) if (mag[i]) n = i + 1;
    return n + 1;
  endfunction

  task automatic run_op(input int idx, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input int gap, input int hold,
                        output logic [63:0] got, output int lat);
    int          w;
    int          exp_lat;
    logic [63:0] exp_p;
    w       = (idx < 2) ? 32 : 8;
    exp_p   = model_product(w, x, y, s);
    exp_lat = model_latency(w, idx % 2, y, s);
    got     = '0;
    repeat (gap) @(negedge clk);
    a[idx] = x; b[idx] = y; sgn[idx] = s; req_val[idx] = 1'b1;
    check("req_rdy_idle", 64'(req_rdy[idx]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    // Operands must be ignored once accepted.
    req_val[idx] = 1'b0;
    a[idx] = $urandom; b[idx] = $urandom; sgn[idx] = 1'($urandom_range(0, 1));
    lat = 1;
    while (!resp_val[idx] && lat < 200) begin
      check("req_rdy_busy", 64'(req_rdy[idx]), 64'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (!resp_val[idx]) return;
    got = res[idx];
    check("result", got, exp_p);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_val", 64'(resp_val[idx]), 64'd1);
      check("hold_result", res[idx], exp_p);
      check("hold_req_rdy", 64'(req_rdy[idx]), 64'd0);
    end
    resp_rdy[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy[idx] = 1'b0;
    check("post_val", 64'(resp_val[idx]), 64'd0);
    check("post_req_rdy", 64'(req_rdy[idx]), 64'd1);
  endtask

  initial begin
    logic [63:0] got;
    int          lat;
    logic        stale;
    reset = 1'b0; a = '0; b = '0; sgn = '0; req_val = '0; resp_rdy = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_req_rdy", 64'(req_rdy[i]), 64'd1);
      check("rst_resp_val", 64'(resp_val[i]), 64'd0);
      check("rst_result", res[i], 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    run_op(0, 32'd5, 32'd3, 1'b1, 0, 0, got, lat);
    check("d5x3_result", got, 64'h0000_0000_0000_000F);
    check("d5x3_latency", 64'(lat), 64'd33);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 0, got, lat);
    check("minneg_signed", got, 64'h0000_0000_8000_0000);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, got, lat);
    check("minneg_unsigned", got, 64'h7FFF_FFFF_8000_0000);
    run_op(1, 32'h1234, 32'd0, 1'b0, 0, 0, got, lat);
    check("et_b0_result", got, 64'd0);
    check("et_b0_latency", 64'(lat), 64'd2);
    run_op(1, 32'h1234, 32'd3, 1'b0, 0, 0, got, lat);
    check("et_b3_result", got, 64'h369C);
    check("et_b3_latency", 64'(lat), 64'd3);
    run_op(0, 32'd123, 32'd456, 1'b0, 0, 10, got, lat);
    check("bp_result", got, 64'd56088);

    // Reset in the CALC cycle where count is 10.
    a[0] = 32'd99; b[0] = 32'd77; sgn[0] = 1'b0; req_val[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_val[0] = 1'b0;
    repeat (10) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_resp_val", 64'(resp_val[0]), 64'd0);
    check("midrst_req_rdy", 64'(req_rdy[0]), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      stale = stale | resp_val[0];
    end
    check("no_stale_resp", 64'(stale), 64'd0);
    run_op(0, -32'sd7, 32'd6, 1'b1, 0, 0, got, lat);
    check("after_rst_result", got, 64'hFFFF_FFFF_FFFF_FFD6);

    for (int n = 0; n < 160; n++) begin
      int          idx, w;
      logic [31:0] x, y;
      idx = n % 4;
      w   = (idx < 2) ? 32 : 8;
      x   = $urandom;
      y   = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 7))
        0: x = 32'd0;
        1: y = 32'd0;
        2: x = 32'd1 << (w - 1);
        3: y = 32'd1 << (w - 1);
        4: x = op_mask(w);
        default: ;
      endcase
      run_op(idx, x & op_mask(w), y & op_mask(w), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), got, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
